// File: rtl/gshare_branch_predictor_pkg.sv
// Shared types and sizing helpers for the gshare direction predictor.
// Queue entries are packed as {idx, pred, hist}, MSB to LSB.
package gshare_branch_predictor_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } bp_state_e;

    function automatic int unsigned entry_width(input int unsigned index_bits,
                                                input int unsigned hist_bits);
        return index_bits + 1 + hist_bits;
    endfunction

    // Weakly-taken value for a counter of the given width.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_inflight_fifo.sv
// In-flight branch queue: pointers carry one extra wrap bit to tell full from empty.
// Flush beats push; push is refused when full, pop is refused when empty.
module branch_inflight_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] PtrOne = 1;

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: PC XOR speculative history indexes saturating counters;
// resolved outcomes update the entry recorded at prediction time via the in-flight queue.
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int unsigned HIST_BITS  = 8,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned INFLIGHT   = 4,
    parameter bit          GSHARE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_branch_addr,
    input  logic [31:0] offset,
    input  logic        branch_decode_sig,
    input  logic        branch_mem_sig,
    input  logic        actual_branch_decision,
    output logic [31:0] out_branch_addr,
    output logic        prediction,
    output logic        mispredict,
    output logic        ready,
    output logic        fifo_full
);

    localparam int unsigned TableDepth = 1 << INDEX_BITS;
    localparam int unsigned EntryW     = entry_width(INDEX_BITS, HIST_BITS);
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CtrMax  = '1;

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [HIST_BITS-1:0]  spec_hist_q, spec_hist_d;
    logic [HIST_BITS-1:0]  commit_hist_q, commit_hist_d;
    logic                  mispredict_q, mispredict_d;
    logic [CTR_BITS-1:0]   ctr_q [TableDepth];

    logic [INDEX_BITS-1:0] hist_ext, idx;
    logic [CTR_BITS-1:0]   rd_ctr, cur_ctr, upd_ctr;
    logic                  push, pop, mispredict_now, fifo_empty;
    logic [EntryW-1:0]     head;
    logic [INDEX_BITS-1:0] head_idx;
    logic                  head_pred;
    logic [HIST_BITS-1:0]  head_hist;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [CTR_BITS-1:0]   tbl_wdata;

    assign out_branch_addr = pc_branch_addr + offset;
    assign ready           = (state_q == StRun);
    assign mispredict      = mispredict_q;

    always_comb begin
        hist_ext = '0;
        hist_ext[HIST_BITS-1:0] = spec_hist_q;
        idx = GSHARE_EN ? (pc_branch_addr[INDEX_BITS+1:2] ^ hist_ext) : hist_ext;
    end

    assign rd_ctr     = ctr_q[idx];
    assign prediction = ready & rd_ctr[CTR_BITS-1];

    assign head_idx  = head[EntryW-1 -: INDEX_BITS];
    assign head_pred = head[HIST_BITS];
    assign head_hist = head[HIST_BITS-1:0];

    assign push           = branch_decode_sig & ready & ~fifo_full;
    assign pop            = branch_mem_sig & ready & ~fifo_empty;
    assign mispredict_now = pop & (actual_branch_decision != head_pred);

    assign cur_ctr = ctr_q[head_idx];
    always_comb begin
        upd_ctr = cur_ctr;
        if (actual_branch_decision) begin
            if (cur_ctr != CtrMax) upd_ctr = cur_ctr + CTR_BITS'(1);
        end else begin
            if (cur_ctr != '0) upd_ctr = cur_ctr - CTR_BITS'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        tbl_we     = 1'b0;
        tbl_waddr  = init_idx_q;
        tbl_wdata  = CtrInit;
        if (state_q == StInit) begin
            tbl_we     = 1'b1;
            init_idx_d = init_idx_q + INDEX_BITS'(1);
            if (init_idx_q == '1) state_d = StRun;
        end else if (pop) begin
            tbl_we    = 1'b1;
            tbl_waddr = head_idx;
            tbl_wdata = upd_ctr;
        end
    end

    // A mispredict repair overrides the shift from a same-cycle decode.
    always_comb begin
        spec_hist_d   = spec_hist_q;
        commit_hist_d = commit_hist_q;
        if (mispredict_now) begin
            spec_hist_d = {head_hist[HIST_BITS-2:0], actual_branch_decision};
        end else if (push) begin
            spec_hist_d = {spec_hist_q[HIST_BITS-2:0], prediction};
        end
        if (pop) commit_hist_d = {commit_hist_q[HIST_BITS-2:0], actual_branch_decision};
        mispredict_d = mispredict_now;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StInit;
            init_idx_q    <= '0;
            spec_hist_q   <= '0;
            commit_hist_q <= '0;
            mispredict_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            spec_hist_q   <= spec_hist_d;
            commit_hist_q <= commit_hist_d;
            mispredict_q  <= mispredict_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_we) ctr_q[tbl_waddr] <= tbl_wdata;
    end

    branch_inflight_fifo #(
        .Width(EntryW),
        .Depth(INFLIGHT)
    ) u_inflight (
        .clk_i  (clk),
        .rst_i  (reset),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(mispredict_now),
        .wdata_i({idx, prediction, spec_hist_q}),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor: address table plus hand-computed sequences.
// Spec history is observed by probing PCs that alias onto a counter with a known value.
module tb_gshare_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_branch_addr;
    logic [31:0] offset;
    logic        branch_decode_sig;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [31:0] out_branch_addr;
    logic        prediction;
    logic        mispredict;
    logic        ready;
    logic        fifo_full;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] exp;
    } addr_vec_t;

    addr_vec_t vecs [5];

    gshare_branch_predictor dut (
        .clk                   (clk),
        .reset                 (reset),
        .pc_branch_addr        (pc_branch_addr),
        .offset                (offset),
        .branch_decode_sig     (branch_decode_sig),
        .branch_mem_sig        (branch_mem_sig),
        .actual_branch_decision(actual_branch_decision),
        .out_branch_addr       (out_branch_addr),
        .prediction            (prediction),
        .mispredict            (mispredict),
        .ready                 (ready),
        .fifo_full             (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: inputs applied at negedge, outputs sampled 1 time unit later.
    task automatic step(input logic dec, input logic mem, input logic act,
                        input logic [31:0] pc);
        @(negedge clk);
        branch_decode_sig      = dec;
        branch_mem_sig         = mem;
        actual_branch_decision = act;
        pc_branch_addr         = pc;
        #1;
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
            #1;
        end
        check(name, n, 256);
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0000_0003, off: 32'h0000_0007, exp: 32'h0000_000A};
        vecs[1] = '{pc: 32'h0000_0000, off: 32'h00FF_FFFF, exp: 32'h00FF_FFFF};
        vecs[2] = '{pc: 32'hFFFF_FFFC, off: 32'h0000_0008, exp: 32'h0000_0004};
        vecs[3] = '{pc: 32'h0000_1000, off: 32'hFFFF_FFF0, exp: 32'h0000_0FF0};
        vecs[4] = '{pc: 32'h8000_0000, off: 32'h8000_0000, exp: 32'h0000_0000};

        reset                  = 1'b1;
        pc_branch_addr         = '0;
        offset                 = '0;
        branch_decode_sig      = 1'b0;
        branch_mem_sig         = 1'b0;
        actual_branch_decision = 1'b0;

        // Target adder follows inputs while held in reset; strobes must be ignored.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pc_branch_addr    = vecs[i].pc;
            offset            = vecs[i].off;
            branch_decode_sig = 1'b1;
            #1;
            check("addr_in_reset", out_branch_addr, vecs[i].exp);
            check("ready_in_reset", ready, 1'b0);
            check("pred_in_reset", prediction, 1'b0);
        end
        check("misp_reset", mispredict, 1'b0);
        check("full_reset", fifo_full, 1'b0);
        branch_decode_sig = 1'b0;
        offset            = '0;

        @(negedge clk);
        reset = 1'b0;
        #1;
        count_init("init_cycles");

        // Mispredict then agree at pc=0; counter[0] ends at 0, history stays 0.
        step(1, 0, 0, 32'h0);   check("p1_pred", prediction, 1'b1);
        step(0, 1, 0, 32'h0);   check("p1_no_early_pulse", mispredict, 1'b0);
        step(1, 0, 0, 32'h0);   check("p1_pulse", mispredict, 1'b1);
                                check("p2_pred", prediction, 1'b0);
        step(0, 1, 0, 32'h0);   check("p1_pulse_one_cycle", mispredict, 1'b0);
        step(0, 0, 0, 32'h0);   check("p2_no_pulse", mispredict, 1'b0);
                                check("ctr0_zero", prediction, 1'b0);
        step(0, 0, 0, 32'h4);   check("hist0_probe", prediction, 1'b1);

        // Fill the queue with four taken predictions at pc=0x40.
        step(1, 0, 0, 32'h40);  check("q1_pred", prediction, 1'b1);
        step(1, 0, 0, 32'h40);  check("q2_pred", prediction, 1'b1);
        step(1, 0, 0, 32'h40);  check("q_full_after2", fifo_full, 1'b0);
        step(1, 0, 0, 32'h40);  check("q_full_after3", fifo_full, 1'b0);
        step(1, 0, 0, 32'h40);  check("q_full_after4", fifo_full, 1'b1);
                                check("q5_pred", prediction, 1'b1);
        step(0, 0, 0, 32'h3C);  check("q5_not_pushed", fifo_full, 1'b1);
                                check("hist_0f_probe", prediction, 1'b0);
        step(0, 0, 0, 32'h38);  check("hist_0f_neg", prediction, 1'b1);

        // Pop, then a simultaneous push+pop, then a push that refills the queue.
        step(0, 1, 1, 32'h0);
        step(1, 1, 1, 32'h40);  check("pop_frees", fifo_full, 1'b0);
                                check("pp_pred", prediction, 1'b1);
        step(1, 0, 0, 32'h40);  check("pp_occ_same", fifo_full, 1'b0);
        step(0, 1, 0, 32'h0);   check("refilled", fifo_full, 1'b1);
                                check("no_misp_yet", mispredict, 1'b0);
        // Head {0x13,1,0x03} resolves not-taken: flush, history repaired to 0x06.
        step(0, 0, 0, 32'h18);  check("flush_pulse", mispredict, 1'b1);
                                check("flush_empty", fifo_full, 1'b0);
                                check("hist_06_probe", prediction, 1'b0);
        step(0, 1, 0, 32'h1C);  check("pulse_ends", mispredict, 1'b0);
                                check("hist_06_neg", prediction, 1'b1);
        step(0, 0, 0, 32'h18);  check("empty_pop_no_pulse", mispredict, 1'b0);
                                check("empty_pop_hist", prediction, 1'b0);

        // Flush beats a same-cycle push.
        step(1, 0, 0, 32'h100); check("fp_pred", prediction, 1'b1);
        step(1, 1, 0, 32'h100); check("fp_pred2", prediction, 1'b1);
        step(0, 1, 0, 32'h30);  check("fp_pulse", mispredict, 1'b1);
                                check("hist_0c_probe", prediction, 1'b0);
        step(0, 0, 0, 32'h30);  check("fp_push_dropped", mispredict, 1'b0);

        // Same-index read during update sees the old counter (0x46 holds 1).
        step(1, 0, 0, 32'h128); check("si_pred", prediction, 1'b0);
        step(1, 1, 1, 32'h178); check("si_pre_update", prediction, 1'b0);
        step(0, 0, 0, 32'h17C); check("si_pulse", mispredict, 1'b1);
                                check("si_post_update", prediction, 1'b1);
        step(0, 1, 0, 32'h17C); check("si_pulse_end", mispredict, 1'b0);
        step(0, 0, 0, 32'h0);   check("si_no_pulse", mispredict, 1'b0);

        // Reset mid-RUN with an entry queued, then again mid-INIT.
        step(1, 0, 0, 32'h0);
        @(negedge clk);
        reset             = 1'b1;
        branch_decode_sig = 1'b0;
        #1;
        check("rst_run_ready", ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check("mid_init_ready", ready, 1'b0);
        pc_branch_addr = 32'h0;
        #1;
        check("mid_init_pred", prediction, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_init_ready", ready, 1'b0);
        check("rst_init_full", fifo_full, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        count_init("reinit_cycles");

        // Queue must be empty after reset: a stale taken entry would mispredict here.
        step(0, 1, 0, 32'h0);
        step(0, 0, 0, 32'h0);   check("stale_cleared", mispredict, 1'b0);
                                check("ctr0_reinit", prediction, 1'b1);

        // Three taken predictions (hist 0x07), then a not-taken resolve.
        step(1, 0, 0, 32'h0);   check("t1_pred", prediction, 1'b1);
        step(1, 0, 0, 32'h0);   check("t2_pred", prediction, 1'b1);
        step(1, 0, 0, 32'h0);   check("t3_pred", prediction, 1'b1);
        step(0, 1, 0, 32'h1C);  check("hist_07_probe", prediction, 1'b1);
        step(0, 0, 0, 32'h0);   check("t_pulse", mispredict, 1'b1);
                                check("t_empty", fifo_full, 1'b0);
                                check("t_hist0", prediction, 1'b0);
        step(0, 1, 0, 32'h1C);  check("t_pulse_end", mispredict, 1'b0);
                                check("t_hist0_neg", prediction, 1'b1);
        step(0, 0, 0, 32'h0);   check("t_queue_empty", mispredict, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
